plot_datapath: RTL and testbench



---
 rtl/plot_pkg.sv | 20 ++
 rtl/half_second_timer.sv | 28 ++
 rtl/plot_datapath.sv | 154 +++++++++++++++
 tb/tb_plot_datapath.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// Shared types and constants for the plot datapath: draw-engine states,
// pixel colours and default screen geometry.
package plot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LETTER,
    ST_GRAPH,
    ST_DONE
  } draw_state_t;

  localparam logic [2:0] BLACK = 3'd0;
  localparam logic [2:0] GREEN = 3'd2;
  localparam logic [2:0] WHITE = 3'd7;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/half_second_timer.sv
// Free-running refresh timer: counts 0..TICK_CYCLES-1 and flags the last
// count with a one-cycle tick.
module half_second_timer #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/plot_datapath.sv
// Pixel-drawing datapath: scans the clear, letter or graph region one pixel
// per cycle on the VGA write port and pulses a done flag per finished pass.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for ld_clear / ld_letter / ld_graph (that priority)
// ST_CLEAR  | writing black over the whole screen
// ST_LETTER | writing the latched 8x8 glyph
// ST_GRAPH  | writing the latched bar level, filled from the bottom
// ST_DONE   | one cycle, raises the done flag of the pass just finished
module plot_datapath
  import plot_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int TICK_CYCLES = 25_000_000,
  parameter int LETTER_X    = 8,
  parameter int LETTER_Y    = 8,
  parameter int GRAPH_X     = 40,
  parameter int GRAPH_Y     = 8,
  parameter int GRAPH_W     = 16,
  parameter int GRAPH_H     = 100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ld_clear,
  input  logic        ld_letter,
  input  logic        ld_graph,
  input  logic [63:0] letter_bits,
  input  logic [6:0]  level,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        done_point5,
  output logic        done_clear,
  output logic        done_plot_letter,
  output logic        done_plot_graph
);

  localparam logic [7:0] SW_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] SH_LAST = 7'(SCREEN_H - 1);
  localparam logic [7:0] GW_LAST = 8'(GRAPH_W - 1);
  localparam logic [6:0] GH_LAST = 7'(GRAPH_H - 1);
  localparam logic [6:0] GH      = 7'(GRAPH_H);
  localparam logic [7:0] LX      = 8'(LETTER_X);
  localparam logic [6:0] LY      = 7'(LETTER_Y);
  localparam logic [7:0] GX      = 8'(GRAPH_X);
  localparam logic [6:0] GY      = 7'(GRAPH_Y);

  draw_state_t state, state_nxt, pass;
  logic [7:0]  cx, col_last;
  logic [6:0]  cy, row_last;
  logic [63:0] bits_q;
  logic [6:0]  level_q;
  logic [5:0]  letter_idx;
  logic        scan_end;
  logic        drawing;

  half_second_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .tick   (done_point5)
  );

  always_comb begin
    col_last = GW_LAST;
    row_last = GH_LAST;
    case (state)
      ST_CLEAR:  begin col_last = SW_LAST; row_last = SH_LAST; end
      ST_LETTER: begin col_last = 8'd7;    row_last = 7'd7;    end
      default:   ;
    endcase
  end

  assign scan_end   = (cx == col_last) && (cy == row_last);
  assign drawing    = (state == ST_CLEAR) || (state == ST_LETTER) || (state == ST_GRAPH);
  // Bit 63 is the glyph's top-left pixel, so the index runs backwards.
  assign letter_idx = 6'd63 - {cy[2:0], cx[2:0]};

  always_comb begin
    state_nxt        = state;
    plot             = 1'b0;
    x                = '0;
    y                = '0;
    colour           = BLACK;
    done_clear       = 1'b0;
    done_plot_letter = 1'b0;
    done_plot_graph  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ld_clear)       state_nxt = ST_CLEAR;
        else if (ld_letter) state_nxt = ST_LETTER;
        else if (ld_graph)  state_nxt = ST_GRAPH;
      end
      ST_CLEAR: begin
        plot = 1'b1;
        x    = cx;
        y    = cy;
        if (scan_end) state_nxt = ST_DONE;
      end
      ST_LETTER: begin
        plot   = 1'b1;
        x      = LX + cx;
        y      = LY + cy;
        colour = bits_q[letter_idx] ? WHITE : BLACK;
        if (scan_end) state_nxt = ST_DONE;
      end
      ST_GRAPH: begin
        plot   = 1'b1;
        x      = GX + cx;
        y      = GY + cy;
        // Row distance from the bottom edge; rows below the level are lit.
        colour = ((GH_LAST - cy) < level_q) ? GREEN : BLACK;
        if (scan_end) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_clear       = (pass == ST_CLEAR);
        done_plot_letter = (pass == ST_LETTER);
        done_plot_graph  = (pass == ST_GRAPH);
        state_nxt        = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      pass    <= ST_IDLE;
      cx      <= '0;
      cy      <= '0;
      bits_q  <= '0;
      level_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && (state_nxt != ST_IDLE)) begin
        pass    <= state_nxt;
        cx      <= '0;
        cy      <= '0;
        bits_q  <= letter_bits;
        level_q <= (level > GH) ? GH : level;
      end else if (drawing) begin
        if (cx == col_last) begin
          cx <= '0;
          if (cy != row_last) cy <= cy + 7'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_plot_datapath.sv
// Randomized self-checking bench for plot_datapath against a pixel-list
// reference model derived from region geometry.
module tb_plot_datapath;

  localparam int TICK = 10;
  localparam int SW = 20, SH = 20;
  localparam int LX = 8, LY = 8;
  localparam int GX = 2, GY = 4, GW = 2, GH = 8;
  localparam int K_CLEAR = 0, K_LETTER = 1, K_GRAPH = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ld_clear = 1'b0, ld_letter = 1'b0, ld_graph = 1'b0;
  logic [63:0] letter_bits = '0;
  logic [6:0]  level = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, done_point5, done_clear, done_plot_letter, done_plot_graph;

  int checks = 0;
  int errors = 0;
  int k = 0;

  always #5 clk = ~clk;

  plot_datapath #(
    .SCREEN_W(SW), .SCREEN_H(SH), .TICK_CYCLES(TICK),
    .LETTER_X(LX), .LETTER_Y(LY), .GRAPH_X(GX), .GRAPH_Y(GY),
    .GRAPH_W(GW), .GRAPH_H(GH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ld_clear(ld_clear), .ld_letter(ld_letter), .ld_graph(ld_graph),
    .letter_bits(letter_bits), .level(level),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .done_point5(done_point5), .done_clear(done_clear),
    .done_plot_letter(done_plot_letter), .done_plot_graph(done_plot_graph)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // k counts clock edges since reset release; the tick belongs to every TICK-th cycle.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
    chk("done_point5", done_point5, ((k % TICK) == TICK - 1));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_plot"}, plot, 0);
    chk({tag, "_xyc"}, {x, y, colour}, 0);
    chk({tag, "_done"}, {done_clear, done_plot_letter, done_plot_graph}, 0);
  endtask

  function automatic int area(input int kind);
    if (kind == K_CLEAR) return SW * SH;
    if (kind == K_LETTER) return 64;
    return GW * GH;
  endfunction

  task automatic exp_pix(input int kind, input int i, input logic [63:0] bits, input int lvl,
                         output int ex, output int ey, output int ec);
    int w, cx, cy, filled;
    w = (kind == K_CLEAR) ? SW : ((kind == K_LETTER) ? 8 : GW);
    cx = i % w;
    cy = i / w;
    ex = cx;
    ey = cy;
    ec = 0;
    if (kind == K_LETTER) begin
      ex = LX + cx;
      ey = LY + cy;
      ec = bits[63 - (8 * cy + cx)] ? 7 : 0;
    end else if (kind == K_GRAPH) begin
      filled = (lvl > GH) ? GH : lvl;
      ex = GX + cx;
      ey = GY + cy;
      ec = (cy >= GH - filled) ? 2 : 0;
    end
  endtask

  task automatic set_ld(input int kind, input logic v);
    case (kind)
      K_CLEAR:  ld_clear = v;
      K_LETTER: ld_letter = v;
      default:  ld_graph = v;
    endcase
  endtask

  task automatic run_pass(input int kind, input bit hold, input bit mid_change);
    logic [63:0] bits;
    logic [2:0]  want;
    int lvl, n, ex, ey, ec;
    set_ld(kind, 1'b1);
    bits = letter_bits;
    lvl  = level;
    n    = area(kind);
    step();
    for (int i = 0; i < n; i++) begin
      exp_pix(kind, i, bits, lvl, ex, ey, ec);
      chk("pix_plot", plot, 1);
      chk("pix_x", x, ex);
      chk("pix_y", y, ey);
      chk("pix_colour", colour, ec);
      chk("pix_done", {done_clear, done_plot_letter, done_plot_graph}, 0);
      if (!hold && i == 0) set_ld(kind, 1'b0);
      if (mid_change && i == n / 2) begin
        letter_bits = {$urandom, $urandom};
        level = 7'($urandom);
      end
      step();
    end
    want = (kind == K_CLEAR) ? 3'b100 : ((kind == K_LETTER) ? 3'b010 : 3'b001);
    chk("done_cycle_plot", plot, 0);
    chk("done_cycle_xyc", {x, y, colour}, 0);
    chk("done_cycle_flags", {done_clear, done_plot_letter, done_plot_graph}, want);
    step();
    check_idle("after_done");
    set_ld(kind, 1'b0);
  endtask

  initial begin
    int kind;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_hold");
    chk("reset_tick", done_point5, 0);
    @(negedge clk);
    resetn = 1'b1;
    k = 0;

    repeat (35) begin
      step();
      check_idle("timer_idle");
    end

    run_pass(K_CLEAR, 1'b1, 1'b0);
    check_idle("no_retrigger");
    step();
    check_idle("no_retrigger2");

    letter_bits = 64'h8000_0000_0000_0001;
    run_pass(K_LETTER, 1'b1, 1'b0);

    level = 7'd3;
    run_pass(K_GRAPH, 1'b0, 1'b1);
    level = 7'd120;
    run_pass(K_GRAPH, 1'b1, 1'b0);
    level = 7'd0;
    run_pass(K_GRAPH, 1'b1, 1'b0);

    // clear beats graph; graph follows only because ld_graph stays high in IDLE
    level = 7'd5;
    ld_graph = 1'b1;
    run_pass(K_CLEAR, 1'b1, 1'b0);
    run_pass(K_GRAPH, 1'b0, 1'b0);

    // letter dropped before the IDLE cycle must not start
    ld_letter = 1'b1;
    run_pass(K_CLEAR, 1'b1, 1'b0);
    ld_letter = 1'b0;
    repeat (3) begin
      step();
      check_idle("dropped_ld");
    end

    // reset in the middle of a clear
    ld_clear = 1'b1;
    step();
    ld_clear = 1'b0;
    repeat (5) step();
    chk("mid_clear_x", x, 5);
    resetn = 1'b0;
    #1;
    check_idle("async_reset");
    chk("async_reset_tick", done_point5, 0);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_held");
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
    step();
    check_idle("post_reset");
    run_pass(K_CLEAR, 1'b0, 1'b0);

    for (int r = 0; r < 14; r++) begin
      kind = ($urandom_range(0, 4) == 0) ? K_CLEAR : int'($urandom_range(1, 2));
      letter_bits = {$urandom, $urandom};
      level = 7'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) level = 7'($urandom);
      run_pass(kind, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin
        step();
        check_idle("rand_gap");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
